prefetch_fill_engine: RTL and testbench

- Producer side of the 8-entry instruction prefetch buffer. Generates sequential fetch addresses, issues in-order memory read requests with a req/gnt handshake, and pushes returned words with their PCs into the buffer write port.
- Uses the buffer's count as flow-control credit, so a buffer write is never dropped for lack of space.
- On flush it redirects to a new PC and discards responses for requests already in flight.

---
 rtl/prefetch_fill_engine.sv | 203 ++++++++++++++++++++
 tb/tb_prefetch_fill_engine.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prefetch_fill_engine.sv
// Producer side of the instruction prefetch buffer: issues sequential word fetches under
// buffer credit, writes in-order responses into the buffer and drops stale ones after a flush.
module prefetch_fill_engine_chk #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       buf_write_enable,
    input  logic [3:0] buf_count
);
    property p_no_write_when_full;
        @(posedge clk) disable iff (!rst_n)
            !(buf_write_enable && (buf_count == 4'(DEPTH)));
    endproperty

    a_no_write_when_full: assert property (p_no_write_when_full);
endmodule

module prefetch_fill_engine #(
    parameter int          DEPTH           = 8,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic [31:0] redirect_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic [3:0]  buf_count,
    output logic        buf_write_enable,
    output logic [31:0] buf_write_data,
    output logic [31:0] buf_write_pc,
    output logic [1:0]  outstanding
);
    localparam int         PW      = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [4:0] DEPTH_W = 5'(DEPTH);
    localparam logic [2:0] MAX_W   = 3'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_RECOVER = 2'd2
    } state_t;

    state_t        state_r;
    state_t        state_s;
    logic [31:0]   fetch_pc_r;
    logic [1:0]    outstanding_r;
    logic [1:0]    stale_r;
    logic [31:0]   pc_q_r [MAX_OUTSTANDING];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic          bwe_r;
    logic [31:0]   bdata_r;
    logic [31:0]   bpc_r;

    logic          push_s;
    logic          pop_s;
    logic          write_s;
    logic          credit_ok_s;
    logic          credit_next_s;
    logic [1:0]    live_s;
    logic [4:0]    sum_s;
    logic [2:0]    out_after_s;
    logic [31:0]   redirect_aligned_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        logic [PW-1:0] r;
        if (p == PW'(MAX_OUTSTANDING - 1)) begin
            r = {PW{1'b0}};
        end else begin
            r = p + PW'(1);
        end
        return r;
    endfunction

    // Credit: committed slots (occupancy + live requests + pending write) must stay below DEPTH.
    // After a grant, a same-cycle live response moves one slot from live to pending write,
    // so the post-grant sum is simply the current sum plus one.
    always_comb begin
        push_s             = mem_req & mem_gnt;
        pop_s              = mem_rvalid & (outstanding_r != 2'd0);
        write_s            = pop_s & ~flush & (stale_r == 2'd0);
        live_s             = outstanding_r - stale_r;
        sum_s              = {1'b0, buf_count} + {3'b000, live_s} + {4'b0000, bwe_r};
        out_after_s        = {1'b0, outstanding_r} + {2'b00, push_s} - {2'b00, pop_s};
        credit_ok_s        = (sum_s < DEPTH_W) & ({1'b0, outstanding_r} < MAX_W);
        credit_next_s      = ((sum_s + 5'd1) < DEPTH_W) & (out_after_s < MAX_W);
        redirect_aligned_s = redirect_pc & 32'hFFFF_FFFC;
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next state; flush wins from any state
    always_comb begin
        state_s = state_r;
        if (flush) begin
            state_s = S_RECOVER;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (credit_ok_s) state_s = S_REQ;
                    else             state_s = S_IDLE;
                end
                S_REQ: begin
                    if (mem_gnt) state_s = credit_next_s ? S_REQ : S_IDLE;
                    else         state_s = S_REQ;
                end
                S_RECOVER: state_s = S_IDLE;
                default:   state_s = S_IDLE;
            endcase
        end
    end

    // FSM outputs
    always_comb begin
        mem_req = 1'b0;
        case (state_r)
            S_REQ:   mem_req = 1'b1;
            default: mem_req = 1'b0;
        endcase
    end

    // Fetch address and in-flight accounting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_r    <= RESET_PC;
            outstanding_r <= 2'd0;
            stale_r       <= 2'd0;
        end else begin
            outstanding_r <= out_after_s[1:0];
            if (flush) begin
                fetch_pc_r <= redirect_aligned_s;
                stale_r    <= out_after_s[1:0];
            end else begin
                if (push_s) fetch_pc_r <= fetch_pc_r + 32'd4;
                else        fetch_pc_r <= fetch_pc_r;
                if (pop_s && (stale_r != 2'd0)) stale_r <= stale_r - 2'd1;
                else                             stale_r <= stale_r;
            end
        end
    end

    // PC queue of granted requests, popped in response order
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) pc_q_r[i] <= 32'h0;
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
        end else begin
            if (push_s) begin
                pc_q_r[wr_ptr_r] <= fetch_pc_r;
                wr_ptr_r         <= ptr_inc(wr_ptr_r);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) rd_ptr_r <= ptr_inc(rd_ptr_r);
            else       rd_ptr_r <= rd_ptr_r;
        end
    end

    // Registered buffer write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bwe_r   <= 1'b0;
            bdata_r <= 32'h0;
            bpc_r   <= 32'h0;
        end else begin
            bwe_r <= write_s;
            if (write_s) begin
                bdata_r <= mem_rdata;
                bpc_r   <= pc_q_r[rd_ptr_r];
            end else begin
                bdata_r <= bdata_r;
                bpc_r   <= bpc_r;
            end
        end
    end

    assign mem_addr         = fetch_pc_r;
    assign buf_write_enable = bwe_r;
    assign buf_write_data   = bdata_r;
    assign buf_write_pc     = bpc_r;
    assign outstanding      = outstanding_r;

    prefetch_fill_engine_chk #(.DEPTH(DEPTH)) u_chk (
        .clk              (clk),
        .rst_n            (rst_n),
        .buf_write_enable (bwe_r),
        .buf_count        (buf_count)
    );
endmodule

// File: tb/tb_prefetch_fill_engine.sv
// Bench for prefetch_fill_engine: transaction-level model of fetch order, in-flight PCs,
// stale marking and buffer occupancy, plus directed scenarios with literal expectations.
module tb_prefetch_fill_engine;
    logic        clk;
    logic        rst_n;
    logic        flush;
    logic [31:0] redirect_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [3:0]  buf_count;
    logic        buf_write_enable;
    logic [31:0] buf_write_data;
    logic [31:0] buf_write_pc;
    logic [1:0]  outstanding;

    logic        w_flush;
    logic [31:0] w_redirect;
    logic        w_req;
    logic [31:0] w_addr;
    logic        w_gnt;
    logic        w_rvalid;
    logic [31:0] w_rdata;
    logic [3:0]  w_bc;
    logic        w_bwe;
    logic [31:0] w_bdata;
    logic [31:0] w_bpc;
    logic [1:0]  w_out;

    prefetch_fill_engine u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .redirect_pc(redirect_pc),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .buf_count(buf_count),
        .buf_write_enable(buf_write_enable), .buf_write_data(buf_write_data),
        .buf_write_pc(buf_write_pc), .outstanding(outstanding)
    );

    prefetch_fill_engine #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk(clk), .rst_n(rst_n), .flush(w_flush), .redirect_pc(w_redirect),
        .mem_req(w_req), .mem_addr(w_addr), .mem_gnt(w_gnt),
        .mem_rvalid(w_rvalid), .mem_rdata(w_rdata), .buf_count(w_bc),
        .buf_write_enable(w_bwe), .buf_write_data(w_bdata),
        .buf_write_pc(w_bpc), .outstanding(w_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic        stale;
    } fl_t;

    int          checks;
    int          errors;
    int          cyc;
    int          req_count;
    int          bc;
    int          rsp_lat;
    int          rd_budget;
    logic        gnt_en;
    logic        rsp_en;
    logic        flush_req;
    logic [31:0] flush_pc;
    logic [31:0] model_pc;
    logic        exp_we;
    logic [31:0] exp_pc;
    logic        hold_prev;
    logic        w_pend;
    logic [31:0] w_pend_addr;
    fl_t         infl_q[$];
    logic [31:0] rsp_addr_q[$];
    int          rsp_cyc_q[$];
    logic [31:0] wlog[$];
    logic [31:0] w_addr_log[$];
    logic [31:0] w_pc_log[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC3C3_A5A5;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare against the model, then advance the model.
    task automatic step();
        fl_t  e;
        logic fire;
        logic rd;
        @(negedge clk);
        cyc++;
        mem_gnt = gnt_en;
        if (rsp_en && (rsp_addr_q.size() > 0) && ((cyc - rsp_cyc_q[0]) >= rsp_lat)) begin
            mem_rvalid = 1'b1;
            mem_rdata  = mem_word(rsp_addr_q[0]);
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = 32'h0;
        end
        flush       = flush_req;
        redirect_pc = flush_pc;
        flush_req   = 1'b0;
        buf_count   = 4'(bc);
        w_rvalid    = w_pend;
        w_rdata     = w_pend ? mem_word(w_pend_addr) : 32'h0;

        check("mem_addr", mem_addr, model_pc);
        check("outstanding", {30'b0, outstanding}, 32'(infl_q.size()));
        check("buf_write_enable", {31'b0, buf_write_enable}, {31'b0, exp_we});
        if (exp_we) begin
            check("buf_write_pc", buf_write_pc, exp_pc);
            check("buf_write_data", buf_write_data, mem_word(exp_pc));
        end
        if (hold_prev) check("mem_req_hold", {31'b0, mem_req}, 32'h1);
        check("write_into_full", {31'b0, buf_write_enable && (bc == 8)}, 32'h0);
        if (buf_write_enable) wlog.push_back(buf_write_pc);

        fire   = mem_req & mem_gnt;
        exp_we = 1'b0;
        if (mem_rvalid && (infl_q.size() > 0)) begin
            e      = infl_q.pop_front();
            void'(rsp_addr_q.pop_front());
            void'(rsp_cyc_q.pop_front());
            exp_we = !e.stale && !flush;
            exp_pc = e.pc;
        end
        if (fire) begin
            e.pc    = model_pc;
            e.stale = 1'b0;
            infl_q.push_back(e);
            rsp_addr_q.push_back(mem_addr);
            rsp_cyc_q.push_back(cyc);
            model_pc = model_pc + 32'd4;
            req_count++;
        end
        hold_prev = mem_req & ~mem_gnt & ~flush;
        if (flush) begin
            foreach (infl_q[i]) infl_q[i].stale = 1'b1;
            model_pc = redirect_pc & 32'hFFFF_FFFC;
        end
        rd = (rd_budget > 0) && (bc > 0);
        if (rd) rd_budget--;
        if (flush) bc = 0;
        else       bc = bc + (buf_write_enable ? 1 : 0) - (rd ? 1 : 0);

        if (w_bwe && (w_pc_log.size() < 3)) begin
            w_pc_log.push_back(w_bpc);
            check("wrap_data", w_bdata, mem_word(w_bpc));
        end
        if (w_req && w_gnt && (w_addr_log.size() < 3)) w_addr_log.push_back(w_addr);
        w_pend      = w_req & w_gnt;
        w_pend_addr = w_addr;
    endtask

    task automatic do_reset(input int preload);
        @(negedge clk);
        rst_n       = 1'b0;
        flush       = 1'b0;
        redirect_pc = 32'h0;
        mem_gnt     = 1'b0;
        mem_rvalid  = 1'b0;
        mem_rdata   = 32'h0;
        w_rvalid    = 1'b0;
        w_rdata     = 32'h0;
        w_pend      = 1'b0;
        w_pend_addr = 32'h0;
        infl_q.delete();
        rsp_addr_q.delete();
        rsp_cyc_q.delete();
        wlog.delete();
        model_pc  = 32'h0;
        exp_we    = 1'b0;
        exp_pc    = 32'h0;
        hold_prev = 1'b0;
        req_count = 0;
        bc        = preload;
        buf_count = 4'(preload);
        gnt_en    = 1'b0;
        rsp_en    = 1'b0;
        rsp_lat   = 1;
        rd_budget = 0;
        flush_req = 1'b0;
        flush_pc  = 32'h0;
        @(negedge clk);
        check("rst_mem_req", {31'b0, mem_req}, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_outstanding", {30'b0, outstanding}, 32'h0);
        check("rst_buf_write_enable", {31'b0, buf_write_enable}, 32'h0);
        check("rst_wrap_addr", w_addr, 32'hFFFF_FFF8);
        check("rst_wrap_outstanding", {30'b0, w_out}, 32'h0);
        rst_n = 1'b1;
    endtask

    task automatic wait_req(input string name);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!mem_req && (n < 20));
        check(name, {31'b0, mem_req}, 32'h1);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        cyc        = 0;
        rst_n      = 1'b0;
        w_flush    = 1'b0;
        w_redirect = 32'h0;
        w_gnt      = 1'b1;
        w_bc       = 4'd0;

        // Reset, then free-running stream with no buffer reads
        do_reset(0);
        gnt_en = 1'b1;
        rsp_en = 1'b1;
        step();
        check("first_req", {31'b0, mem_req}, 32'h1);
        check("first_addr", mem_addr, 32'h0);
        repeat (30) step();
        check("stream_req_count", 32'(req_count), 32'd8);
        check("stream_req_low", {31'b0, mem_req}, 32'h0);
        check("stream_buf_count", 32'(bc), 32'd8);
        check("stream_writes", 32'(wlog.size()), 32'd8);
        for (int i = 0; i < wlog.size() && i < 8; i++) check("stream_write_pc", wlog[i], 32'(4 * i));

        check("wrap_addr_count", 32'(w_addr_log.size()), 32'd3);
        check("wrap_pc_count", 32'(w_pc_log.size()), 32'd3);
        if (w_addr_log.size() == 3 && w_pc_log.size() == 3) begin
            check("wrap_addr0", w_addr_log[0], 32'hFFFF_FFF8);
            check("wrap_addr1", w_addr_log[1], 32'hFFFF_FFFC);
            check("wrap_addr2", w_addr_log[2], 32'h0000_0000);
            check("wrap_pc0", w_pc_log[0], 32'hFFFF_FFF8);
            check("wrap_pc1", w_pc_log[1], 32'hFFFF_FFFC);
            check("wrap_pc2", w_pc_log[2], 32'h0000_0000);
        end

        // Grant held low: address must not move until granted
        do_reset(0);
        flush_req = 1'b1;
        flush_pc  = 32'h100;
        step();
        step();
        check("stall_recover_idle", {31'b0, mem_req}, 32'h0);
        wait_req("stall_wait_req");
        for (int i = 0; i < 5; i++) begin
            check("stall_req", {31'b0, mem_req}, 32'h1);
            check("stall_addr", mem_addr, 32'h100);
            if (i < 4) step();
        end
        gnt_en = 1'b1;
        step();
        step();
        check("stall_advance_addr", mem_addr, 32'h104);

        // Flush with two requests in flight: both responses are dropped
        do_reset(0);
        flush_req = 1'b1;
        flush_pc  = 32'h40;
        step();
        wait_req("flush_wait_req0");
        gnt_en = 1'b1;
        repeat (3) step();
        check("flush_two_outstanding", {30'b0, outstanding}, 32'd2);
        check("flush_idle_before", {31'b0, mem_req}, 32'h0);
        flush_req = 1'b1;
        flush_pc  = 32'h2003;
        step();
        rsp_en = 1'b1;
        wlog.delete();
        step();
        check("flush_recover_idle", {31'b0, mem_req}, 32'h0);
        wait_req("flush_wait_req1");
        check("flush_new_addr", mem_addr, 32'h2000);
        for (int n = 0; n < 20 && wlog.size() == 0; n++) step();
        check("flush_first_write_pc", (wlog.size() > 0) ? wlog[0] : 32'hFFFF_FFFF, 32'h2000);

        // Credit at the buffer boundary
        do_reset(7);
        gnt_en = 1'b1;
        rsp_en = 1'b1;
        repeat (8) step();
        check("credit_one_req", 32'(req_count), 32'd1);
        check("credit_full", 32'(bc), 32'd8);
        check("credit_req_low", {31'b0, mem_req}, 32'h0);
        rd_budget = 1;
        repeat (12) step();
        check("credit_second_req", 32'(req_count), 32'd2);
        check("credit_full_again", 32'(bc), 32'd8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
